// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Captures an upstream shift word and ones count on each falling
//               edge of shift_en and scans them onto a multiplexed
//               common-anode 7-segment display (hex digits + count digit).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 4,
    localparam int NUM_DIG    = WIDTH / 4 + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic [WIDTH-1:0]   word_in,
    input  logic [3:0]         count_in,
    output logic [NUM_DIG-1:0] an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [7:0]         frames
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIG);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    logic             shift_en_d;
    logic [WIDTH-1:0] word_r;
    logic [3:0]       cnt_r;
    logic             valid;
    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] dig_idx;

    logic             cap;
    logic [3:0]       nib;
    logic             is_cnt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign cap = shift_en_d & ~shift_en;

    // Capture path: the end of a shift burst latches the upstream word/count.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_en_d <= 1'b0;
            word_r     <= '0;
            cnt_r      <= '0;
            valid      <= 1'b0;
            frames     <= 8'd0;
        end else begin
            shift_en_d <= shift_en;
            if (cap) begin
                word_r <= word_in;
                cnt_r  <= count_in;
                valid  <= 1'b1;
                frames <= frames + 8'd1;
            end
        end
    end

    // Free-running digit scan, independent of captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        nib    = cnt_r;
        is_cnt = 1'b1;
        for (int k = 0; k < NUM_DIG - 1; k++) begin
            if (dig_idx == IDX_W'(k)) begin
                nib    = word_r[4*k +: 4];
                is_cnt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !valid) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIG'(1) << dig_idx);
            seg <= hex7(nib);
            dp  <= ~is_cnt;
        end
    end

endmodule
`default_nettype wire
